stack_pointer_unit: RTL and testbench

STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

---
 rtl/stack_pointer_unit.sv | 147 ++++++++++++++
 tb/tb_stack_pointer_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit
//
// Byte-granular stack pointer for a downward-growing stack. The stack is empty
// when sp == STACK_TOP and full when sp == STACK_LIMIT. A push or pop that
// would leave the window [STACK_LIMIT, STACK_TOP] is rejected. A rejected push
// sets the sticky overflow flag, and a rejected pop sets the sticky underflow
// flag. Either rejection parks the unit in the FAULT state, where push and pop
// are ignored until a load or clr_fault returns it to RUN.
//
// Parameters
//   ADDR_W      pointer width in bits
//   STACK_TOP   empty-stack pointer value and the reset value of sp
//   STACK_LIMIT lowest legal sp value (the full boundary)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active low
//   enable     qualifies load, push, pop and clr_fault
//   load       sp <= inAddr (no range check), clear flags, enter RUN
//   push       sp <= sp - 2^step when legal
//   pop        sp <= sp + 2^step when legal
//   step       log2 of the byte count per push/pop
//   clr_fault  clear both flags and enter RUN, sp unchanged
//   inAddr     load value
//   sp         registered stack pointer
//   empty      sp == STACK_TOP
//   full       sp == STACK_LIMIT
//   overflow   sticky: a push was rejected
//   underflow  sticky: a pop was rejected
//   fault      unit is in the FAULT state
module stack_pointer_unit #(
  parameter int unsigned            ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]      STACK_TOP   = 16'h0100,
  parameter logic [ADDR_W-1:0]      STACK_LIMIT = 16'h00F0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic              push,
  input  logic              pop,
  input  logic [1:0]        step,
  input  logic              clr_fault,
  input  logic [ADDR_W-1:0] inAddr,
  output logic [ADDR_W-1:0] sp,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              fault
);

  typedef enum logic [0:0] {
    StRun,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  // The arithmetic is one bit wider than the pointer. This keeps the borrow
  // from a push and the carry from a pop visible.
  logic [ADDR_W:0] step_bytes;
  logic [ADDR_W:0] push_res;
  logic [ADDR_W:0] pop_res;
  logic            push_bad;
  logic            pop_bad;

  always_comb begin
    step_bytes = '0;
    unique case (step)
      2'd0:    step_bytes = (ADDR_W+1)'(1);
      2'd1:    step_bytes = (ADDR_W+1)'(2);
      2'd2:    step_bytes = (ADDR_W+1)'(4);
      default: step_bytes = (ADDR_W+1)'(8);
    endcase
  end

  assign push_res = {1'b0, sp_q} - step_bytes;
  assign pop_res  = {1'b0, sp_q} + step_bytes;

  // A borrow sets the top bit, so it is tested separately from the
  // magnitude compare. A carry already makes pop_res exceed STACK_TOP.
  assign push_bad = push_res[ADDR_W] || (push_res < {1'b0, STACK_LIMIT});
  assign pop_bad  = pop_res > {1'b0, STACK_TOP};

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (enable) begin
      if (load) begin
        sp_d        = inAddr;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        state_d     = StRun;
      end else if (clr_fault) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        state_d     = StRun;
      end else if (state_q == StRun) begin
        // Simultaneous push and pop cancel and leave everything unchanged.
        if (push && !pop) begin
          if (push_bad) begin
            overflow_d = 1'b1;
            state_d    = StFault;
          end else begin
            sp_d = push_res[ADDR_W-1:0];
          end
        end else if (pop && !push) begin
          if (pop_bad) begin
            underflow_d = 1'b1;
            state_d     = StFault;
          end else begin
            sp_d = pop_res[ADDR_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      sp_q        <= STACK_TOP;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign sp        = sp_q;
  assign empty     = (sp_q == STACK_TOP);
  assign full      = (sp_q == STACK_LIMIT);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign fault     = (state_q == StFault);

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed testbench for stack_pointer_unit with the default parameters
// (ADDR_W=16, STACK_TOP=0x0100, STACK_LIMIT=0x00F0).
module tb_stack_pointer_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic        push;
  logic        pop;
  logic [1:0]  step;
  logic        clr_fault;
  logic [15:0] inAddr;
  logic [15:0] sp;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
  logic        fault;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  stack_pointer_unit dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .push      (push),
    .pop       (pop),
    .step      (step),
    .clr_fault (clr_fault),
    .inAddr    (inAddr),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Checks sp together with every flag.
  task automatic chk_all(input string tag, input logic [15:0] e_sp, input logic e_empty,
                         input logic e_full, input logic e_ovf, input logic e_udf,
                         input logic e_fault);
    chk({tag, ".sp"}, sp, e_sp);
    chk({tag, ".empty"}, 16'(empty), 16'(e_empty));
    chk({tag, ".full"}, 16'(full), 16'(e_full));
    chk({tag, ".ovf"}, 16'(overflow), 16'(e_ovf));
    chk({tag, ".udf"}, 16'(underflow), 16'(e_udf));
    chk({tag, ".fault"}, 16'(fault), 16'(e_fault));
  endtask

  task automatic do_load(input logic [15:0] a);
    load   = 1'b1;
    inAddr = a;
    tick();
    load   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; load = 1'b0; push = 1'b0; pop = 1'b0;
    step = 2'd0; clr_fault = 1'b0; inAddr = 16'h0000;
    #2;

    // Reset for one cycle.
    tick();
    chk_all("reset", 16'h0100, 1, 0, 0, 0, 0);
    reset  = 1'b1;
    enable = 1'b1;

    // Push and pop with a step of 2 bytes.
    do_load(16'h00F8);
    chk_all("load_f8", 16'h00F8, 0, 0, 0, 0, 0);
    push = 1'b1; step = 2'd1;
    tick(); chk("push1", sp, 16'h00F6);
    tick(); chk("push2", sp, 16'h00F4);
    tick(); chk("push3", sp, 16'h00F2);
    tick(); chk_all("push4_full", 16'h00F0, 0, 1, 0, 0, 0);
    push = 1'b0; pop = 1'b1;
    tick(); chk("pop1", sp, 16'h00F2);
    tick(); chk("pop2", sp, 16'h00F4);
    tick(); chk("pop3", sp, 16'h00F6);
    tick(); chk_all("pop4", 16'h00F8, 0, 0, 0, 0, 0);
    pop = 1'b0;

    // Overflow: 0xF2 - 4 = 0xEE is below the limit.
    do_load(16'h00F2);
    push = 1'b1; step = 2'd2;
    tick(); chk_all("ovf", 16'h00F2, 0, 0, 1, 0, 1);
    tick(); chk_all("ovf_push_ign", 16'h00F2, 0, 0, 1, 0, 1);
    push = 1'b0; pop = 1'b1; step = 2'd0;
    tick(); chk_all("ovf_pop_ign", 16'h00F2, 0, 0, 1, 0, 1);
    pop = 1'b0;
    // clr_fault has no effect while enable is low.
    enable = 1'b0; clr_fault = 1'b1;
    tick(); chk_all("clr_disabled", 16'h00F2, 0, 0, 1, 0, 1);
    enable = 1'b1;
    tick(); chk_all("clr_fault", 16'h00F2, 0, 0, 0, 0, 0);
    clr_fault = 1'b0;

    // Underflow: a pop landing on the top is legal, and the next pop is not.
    do_load(16'h00FE);
    pop = 1'b1; step = 2'd1;
    tick(); chk_all("pop_to_top", 16'h0100, 1, 0, 0, 0, 0);
    step = 2'd0;
    tick(); chk_all("udf", 16'h0100, 1, 0, 0, 1, 1);
    pop = 1'b0;
    do_load(16'h00F0);
    chk_all("load_clears", 16'h00F0, 0, 1, 0, 0, 0);

    // enable=0 holds state even with load and push asserted.
    enable = 1'b0; load = 1'b1; push = 1'b1; inAddr = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("hold_sp", sp, 16'h00F0);
    end
    enable = 1'b1; load = 1'b0; push = 1'b1; pop = 1'b1;
    tick(); chk_all("push_pop_conflict", 16'h00F0, 0, 1, 0, 0, 0);
    pop = 1'b0;

    // A push starting at the limit is rejected.
    tick(); chk_all("push_at_limit", 16'h00F0, 0, 1, 1, 0, 1);
    // Load has priority over clr_fault and push, and the load value is not range-checked.
    load = 1'b1; clr_fault = 1'b1; inAddr = 16'h0002; step = 2'd2;
    tick(); chk_all("load_prio", 16'h0002, 0, 0, 0, 0, 0);
    load = 1'b0; clr_fault = 1'b0;
    // 2 - 4 borrows past zero and overflows.
    tick(); chk_all("push_wrap", 16'h0002, 0, 0, 1, 0, 1);
    push = 1'b0;
    // 0xFFFC + 8 carries out and underflows.
    do_load(16'hFFFC);
    pop = 1'b1; step = 2'd3;
    tick(); chk_all("pop_carry", 16'hFFFC, 0, 0, 0, 1, 1);
    pop = 1'b0;

    // Reset mid-operation while in FAULT discards the same-cycle command.
    do_load(16'h00F0);
    push = 1'b1; step = 2'd0;
    tick(); chk("pre_rst_fault", 16'(fault), 16'd1);
    reset = 1'b0; load = 1'b1; inAddr = 16'h1234;
    tick(); chk_all("mid_reset", 16'h0100, 1, 0, 0, 0, 0);
    reset = 1'b1; load = 1'b0; push = 1'b0;
    tick(); chk_all("post_reset", 16'h0100, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
